bus_source_encoder: RTL and testbench
=====================================

Name: bus_source_encoder

Overview:
- Sits on the control-unit side of the shared 32-bit datapath bus, upstream of the 24-input bus source multiplexer.
- Converts the control unit's one-hot "out" strobes into the registered 5-bit source select code that the multiplexer consumes.
- Resolves multi-hot strobes by fixed priority and supports bus lock.
- Reports idle and conflict status, with sticky error and saturating diagnostic counters for verification and debug.

Parameters:
NUM_SRC, 24, number of bus sources / strobe width (max 32)
SEL_W, 5, select code width
CNT_W, 8, width of conflict and idle counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
src_out  input  NUM_SRC  one-hot drive strobes; bit i requests source i (0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C_sign_ext)
bus_lock  input  1  freeze current select and valid
err_clr  input  1  clear sticky conflict flag and both counters
select  output  SEL_W  registered select code to bus multiplexer
sel_valid  output  1  registered: select reflects a strobe sampled last cycle
conflict  output  1  registered: more than one strobe sampled last cycle
conflict_sticky  output  1  set on any conflict, held until err_clr
conflict_cnt  output  CNT_W  saturating count of conflict cycles
idle_cnt  output  CNT_W  saturating count of cycles with no strobe and no lock

Behaviour:
- Reset (async, rst_n=0): select=0, sel_valid=0, conflict=0, conflict_sticky=0, conflict_cnt=0, idle_cnt=0. Outputs hold these values while rst_n is low, independent of clk.
- Reset release mid-operation: the first rising edge after rst_n rises samples src_out normally. No strobe seen before reset is remembered.
- Latency: a strobe sampled at edge N appears on select/sel_valid after edge N. The bus multiplexer registers again, so bus data is valid after edge N+1.
- Each edge with rst_n=1 and bus_lock=0:
  - Exactly one bit i set: select=i, sel_valid=1, conflict=0.
  - Two or more bits set: select=lowest set index, sel_valid=1, conflict=1, conflict_sticky=1, conflict_cnt increments (saturates at all-ones).
  - No bits set: select holds its previous value, sel_valid=0, conflict=0, idle_cnt increments (saturates).
- bus_lock=1: select, sel_valid and conflict hold. src_out is ignored: no conflict detection, no counter updates, idle_cnt not incremented.
- err_clr=1: conflict_sticky=0 and both counters=0 on that edge; err_clr has priority over increment.
  - err_clr with a simultaneous conflict: sticky is still cleared and conflict_cnt=0, but the conflict output itself =1.
  - err_clr with bus_lock: clear still applies.
- Counter saturation: at 2^CNT_W-1, further events leave the count unchanged; no wrap.
- Bits at index >= NUM_SRC do not exist. select never exceeds NUM_SRC-1.
- Purely synchronous apart from reset. No combinational path from src_out to any output.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with src_out=0x000010 -> all outputs 0 immediately. Release rst_n; next edge with src_out=0x100000 (PC) -> select=20, sel_valid=1.
- Single-source sweep: drive each one-hot bit 0..23 on consecutive cycles -> select tracks index with 1-cycle lag, sel_valid=1, conflict=0, conflict_cnt=0.
- Conflict: src_out=0x200004 (R2+MDR) -> select=2, conflict=1, conflict_sticky=1, conflict_cnt=1. Next cycle src_out=0x000008 -> select=3, conflict=0, sticky still 1.
- Idle and hold: select=21, then src_out=0 for 3 cycles -> select stays 21, sel_valid=0, idle_cnt=3.
- Lock: select=5, bus_lock=1 while src_out=0x000300 for 4 cycles -> select=5, conflict=0, counters unchanged. Drop lock with src_out=0x000100 -> select=8.
- Saturation and clear: 300 consecutive conflict cycles -> conflict_cnt=255. err_clr=1 together with a conflict -> conflict_cnt=0, conflict_sticky=0, conflict=1.

Source files
------------

// File: rtl/bus_source_encoder.sv
// ============================================================================
//  Module   : bus_source_encoder
//  Purpose  : Registered priority encoder from one-hot bus drive strobes to the
//             bus multiplexer select code, with lock, conflict and idle status.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_source_encoder #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_out,
  input  logic               bus_lock,
  input  logic               err_clr,
  output logic [SEL_W-1:0]   select,
  output logic               sel_valid,
  output logic               conflict,
  output logic               conflict_sticky,
  output logic [CNT_W-1:0]   conflict_cnt,
  output logic [CNT_W-1:0]   idle_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [SEL_W-1:0] w_low_idx;
  logic             w_any;
  logic             w_multi;
  logic             w_upd;

  logic [SEL_W-1:0] r_select;
  logic             r_sel_valid;
  logic             r_conflict;
  logic             r_sticky;
  logic [CNT_W-1:0] r_conflict_cnt;
  logic [CNT_W-1:0] r_idle_cnt;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        w_low_idx = SEL_W'(i);
      end
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means multi-hot.
  assign w_any   = |src_out;
  assign w_multi = |(src_out & (src_out - NUM_SRC'(1)));
  assign w_upd   = ~bus_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_select    <= '0;
      r_sel_valid <= 1'b0;
      r_conflict  <= 1'b0;
    end else if (w_upd) begin
      if (w_any) begin
        r_select <= w_low_idx;
      end
      r_sel_valid <= w_any;
      r_conflict  <= w_multi;
    end
  end

  // Clear outranks both lock and new events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky       <= 1'b0;
      r_conflict_cnt <= '0;
      r_idle_cnt     <= '0;
    end else if (err_clr) begin
      r_sticky       <= 1'b0;
      r_conflict_cnt <= '0;
      r_idle_cnt     <= '0;
    end else if (w_upd) begin
      if (w_multi) begin
        r_sticky <= 1'b1;
        if (r_conflict_cnt != c_cnt_max) begin
          r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
      end
      if (!w_any && (r_idle_cnt != c_cnt_max)) begin
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end
    end
  end

  assign select          = r_select;
  assign sel_valid       = r_sel_valid;
  assign conflict        = r_conflict;
  assign conflict_sticky = r_sticky;
  assign conflict_cnt    = r_conflict_cnt;
  assign idle_cnt        = r_idle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bus_source_encoder.sv
// ============================================================================
//  Module   : tb_bus_source_encoder
//  Purpose  : Directed self-checking bench for bus_source_encoder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_source_encoder;

  logic        clk;
  logic        rst_n;
  logic [23:0] src_out;
  logic        bus_lock;
  logic        err_clr;
  logic [4:0]  select;
  logic        sel_valid;
  logic        conflict;
  logic        conflict_sticky;
  logic [7:0]  conflict_cnt;
  logic [7:0]  idle_cnt;

  int r_errors = 0;
  int r_checks = 0;

  bus_source_encoder #(
    .NUM_SRC(24),
    .SEL_W  (5),
    .CNT_W  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_out        (src_out),
    .bus_lock       (bus_lock),
    .err_clr        (err_clr),
    .select         (select),
    .sel_valid      (sel_valid),
    .conflict       (conflict),
    .conflict_sticky(conflict_sticky),
    .conflict_cnt   (conflict_cnt),
    .idle_cnt       (idle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 ns later.
  task automatic cycle(input logic [23:0] s, input logic lk, input logic clr);
    src_out  = s;
    bus_lock = lk;
    err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [4:0] sel, input logic vld,
                           input logic cf, input logic st, input logic [7:0] cc,
                           input logic [7:0] ic);
    check({tag, ".select"},    32'(select),          32'(sel));
    check({tag, ".valid"},     32'(sel_valid),       32'(vld));
    check({tag, ".conflict"},  32'(conflict),        32'(cf));
    check({tag, ".sticky"},    32'(conflict_sticky), 32'(st));
    check({tag, ".cfl_cnt"},   32'(conflict_cnt),    32'(cc));
    check({tag, ".idle_cnt"},  32'(idle_cnt),        32'(ic));
  endtask

  initial begin
    rst_n    = 1'b0;
    src_out  = '0;
    bus_lock = 1'b0;
    err_clr  = 1'b0;

    #12;
    check_all("por", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    rst_n = 1'b1;

    // Build non-zero state, then assert reset mid-cycle.
    cycle(24'h000010, 1'b0, 1'b0);
    check_all("pre_rst", 5'd4, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    #3;
    rst_n = 1'b1;
    cycle(24'h100000, 1'b0, 1'b0);
    check_all("rst_rel_pc", 5'd20, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

    // One-hot sweep.
    for (int i = 0; i < 24; i++) begin
      cycle(24'(1) << i, 1'b0, 1'b0);
      check("sweep.select", 32'(select), 32'(i));
      check("sweep.valid", 32'(sel_valid), 32'd1);
      check("sweep.conflict", 32'(conflict), 32'd0);
    end
    check("sweep.cfl_cnt", 32'(conflict_cnt), 32'd0);

    // Conflict R2+MDR resolves to R2.
    cycle(24'h200004, 1'b0, 1'b0);
    check_all("conflict", 5'd2, 1'b1, 1'b1, 1'b1, 8'd1, 8'd0);
    cycle(24'h000008, 1'b0, 1'b0);
    check_all("after_conf", 5'd3, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0);

    // Idle holds select.
    cycle(24'h200000, 1'b0, 1'b0);
    check("mdr.select", 32'(select), 32'd21);
    for (int k = 1; k <= 3; k++) begin
      cycle(24'h0, 1'b0, 1'b0);
      check_all("idle", 5'd21, 1'b0, 1'b0, 1'b1, 8'd1, 8'(k));
    end

    // Lock freezes everything, even a multi-hot strobe.
    cycle(24'h000020, 1'b0, 1'b0);
    check_all("r5", 5'd5, 1'b1, 1'b0, 1'b1, 8'd1, 8'd3);
    for (int k = 0; k < 4; k++) begin
      cycle(24'h000300, 1'b1, 1'b0);
      check_all("lock", 5'd5, 1'b1, 1'b0, 1'b1, 8'd1, 8'd3);
    end
    cycle(24'h0, 1'b1, 1'b0);
    check_all("lock_idle", 5'd5, 1'b1, 1'b0, 1'b1, 8'd1, 8'd3);
    cycle(24'h000100, 1'b0, 1'b0);
    check_all("unlock", 5'd8, 1'b1, 1'b0, 1'b1, 8'd1, 8'd3);

    // Conflict counter saturation (starts at 1).
    for (int k = 0; k < 253; k++) cycle(24'h000003, 1'b0, 1'b0);
    check("sat.cnt_254", 32'(conflict_cnt), 32'd254);
    cycle(24'h000003, 1'b0, 1'b0);
    check("sat.cnt_255", 32'(conflict_cnt), 32'd255);
    for (int k = 0; k < 46; k++) cycle(24'h000003, 1'b0, 1'b0);
    check_all("sat", 5'd0, 1'b1, 1'b1, 1'b1, 8'd255, 8'd3);

    // Clear together with a conflict.
    cycle(24'h000006, 1'b0, 1'b1);
    check_all("clr_conf", 5'd1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    cycle(24'h000006, 1'b0, 1'b0);
    check_all("post_clr", 5'd1, 1'b1, 1'b1, 1'b1, 8'd1, 8'd0);

    // Clear under lock.
    cycle(24'h0, 1'b0, 1'b0);
    check_all("idle2", 5'd1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
    cycle(24'h000300, 1'b1, 1'b1);
    check_all("lock_clr", 5'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Idle counter saturation.
    for (int k = 0; k < 260; k++) cycle(24'h0, 1'b0, 1'b0);
    check("idle_sat", 32'(idle_cnt), 32'd255);
    check("idle_sat.sel", 32'(select), 32'd1);

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule

`default_nettype wire
